rca_seq_ctrl: RTL and testbench

Sequencing controller that performs WIDTH-bit add/subtract operations on a single shared 4-bit ripple-carry adder slice (RCA4-equivalent nibble adder: 4-bit A, 4-bit B, carry-in, 4-bit sum, carry-out). Each operand pair is processed one nibble per clock, LSB nibble first, with the carry registered between nibbles. A valid/ready handshake sits on both input and output. The block is the arithmetic front end for wider datapaths built from the lab's 4-bit adder.

---
 rtl/rca_seq_ctrl.sv | 115 +++++++++++
 tb/tb_rca_seq_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rca_seq_ctrl.sv
// ============================================================================
// Module      : rca_seq_ctrl
// Description : WIDTH-bit add/subtract sequenced over a single 4-bit
//               ripple-carry slice, one nibble per clock, LSB nibble first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rca_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [CW+1:0]    w_lo;
    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic [4:0]       w_nib_full;
    logic             w_last;

    // The shared nibble adder: operand slice selected by the nibble counter.
    assign w_lo       = {cnt_q, 2'b00};
    assign w_nib_a    = a_q[w_lo +: 4];
    assign w_nib_b    = b_q[w_lo +: 4];
    assign w_nib_full = {1'b0, w_nib_a} + {1'b0, w_nib_b} + {4'b0000, c_q};
    assign w_last     = (cnt_q == C_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        c_q     <= sub ? 1'b1 : cin;
                        cnt_q   <= '0;
                        state_q <= S_ADD;
                    end
                end
                S_ADD: begin
                    sum_q[w_lo +: 4] <= w_nib_full[3:0];
                    c_q              <= w_nib_full[4];
                    if (w_last) begin
                        cout_q  <= w_nib_full[4];
                        // Signed overflow: like-signed operands, result sign differs.
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (w_nib_full[3] != a_q[WIDTH-1]);
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_rca_seq_ctrl.sv
// ============================================================================
// Module      : tb_rca_seq_ctrl
// Description : Directed self-checking bench for rca_seq_ctrl (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rca_seq_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands in IDLE, take the accept edge, drop in_valid.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                            input logic ts);
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    // Four ADD cycles; out_valid must rise exactly after the fourth edge.
    task automatic wait_done(input logic noise);
        for (int i = 1; i <= 4; i++) begin
            if (noise) begin
                a = 16'($urandom); b = 16'($urandom);
                cin = i[0]; sub = ~i[0]; in_valid = i[0];
            end
            @(posedge clk); #1;
            if (i < 4) begin
                check("out_valid_during_add", {31'd0, out_valid}, 32'd0);
                check("in_ready_during_add", {31'd0, in_ready}, 32'd0);
            end else begin
                check("out_valid_latency", {31'd0, out_valid}, 32'd1);
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] es, input logic ec,
                                input logic eo);
        check({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    endtask

    task automatic release_done();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_release", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_release", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tc, input logic ts, input logic [15:0] es,
                          input logic ec, input logic eo);
        start_op(ta, tb_, tc, ts);
        wait_done(1'b0);
        check_result(tag, es, ec, eo);
        release_done();
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check_result("rst", 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("add_basic",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("carry_b1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("carry_cin",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_nobor",  16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("ovf_add",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("ovf_sub",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Back-pressure with input noise during ADD and DONE.
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_done(1'b1);
        for (int i = 0; i < 5; i++) begin
            a = 16'($urandom); b = 16'($urandom); in_valid = ~in_valid;
            @(posedge clk); #1;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_result("bp", 16'h5555, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        release_done();
        @(posedge clk); #1;
        check("no_second_op", {31'd0, busy}, 32'd0);

        // Reset asserted in the second ADD cycle.
        start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_sum", {16'd0, sum}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op("after_rst", 16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
